// File: rtl/scfifo.sv
// scfifo: single-clock first-word-fall-through FIFO with thresholds, count and sticky error flags
module scfifo #(
   parameter int WIDTH         = 32,
   parameter int LOGDEPTH      = 5,
   parameter int AFULL_THRESH  = 8,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                wrpush,
   input  logic [WIDTH-1:0]    wrdata,
   output logic                full,
   output logic                afull,
   input  logic                rdpop,
   output logic [WIDTH-1:0]    rddata,
   output logic                rdvalid,
   output logic                aempty,
   output logic [LOGDEPTH:0]   count,
   output logic                overflow,
   output logic                underflow
);
   localparam int DEPTH = 1 << LOGDEPTH;
   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [LOGDEPTH-1:0] r_wrptr, r_rdptr;
   logic                w_wr_ok, w_rd_ok;
   logic [LOGDEPTH:0]   w_count_next;
   assign w_rd_ok      = rdpop & rdvalid;
   assign w_wr_ok      = wrpush & (~full | w_rd_ok);
   assign w_count_next = count + (LOGDEPTH+1)'(w_wr_ok) - (LOGDEPTH+1)'(w_rd_ok);
   assign rddata       = r_mem[r_rdptr];
   // storage write; contents deliberately survive reset, only the pointers are cleared
   always_ff @(posedge clk)
      if (reset_n && w_wr_ok) r_mem[r_wrptr] <= wrdata;
   // pointers, occupancy, flags derived from the next count, and sticky error flags
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wrptr   <= '0;
         r_rdptr   <= '0;
         count     <= '0;
         rdvalid   <= 1'b0;
         full      <= 1'b0;
         afull     <= 1'b0;
         aempty    <= 1'b1;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         r_wrptr   <= r_wrptr + LOGDEPTH'(w_wr_ok);
         r_rdptr   <= r_rdptr + LOGDEPTH'(w_rd_ok);
         count     <= w_count_next;
         rdvalid   <= w_count_next != '0;
         full      <= w_count_next == (LOGDEPTH+1)'(DEPTH);
         afull     <= w_count_next >= (LOGDEPTH+1)'(AFULL_THRESH);
         aempty    <= w_count_next <= (LOGDEPTH+1)'(AEMPTY_THRESH);
         overflow  <= overflow | (wrpush & ~w_wr_ok);
         underflow <= underflow | (rdpop & ~rdvalid);
      end
   end
endmodule

// File: tb/tb_scfifo.sv
// tb_scfifo: directed scoreboard bench for scfifo (WIDTH=8, LOGDEPTH=2, AFULL=3, AEMPTY=1)
module tb_scfifo;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       wrpush = 1'b0;
   logic [7:0] wrdata = '0;
   logic       rdpop = 1'b0;
   logic       full, afull, rdvalid, aempty, overflow, underflow;
   logic [7:0] rddata;
   logic [2:0] count;
   logic [7:0] q[$];
   logic       m_ovf = 1'b0, m_unf = 1'b0;
   int         n_chk = 0, n_fail = 0;

   scfifo #(.WIDTH(8), .LOGDEPTH(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut (
      .clk(clk), .reset_n(reset_n), .wrpush(wrpush), .wrdata(wrdata), .full(full),
      .afull(afull), .rdpop(rdpop), .rddata(rddata), .rdvalid(rdvalid), .aempty(aempty),
      .count(count), .overflow(overflow), .underflow(underflow));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      chk("count", 32'(count), 32'(q.size()));
      chk("rdvalid", 32'(rdvalid), 32'(q.size() != 0));
      chk("full", 32'(full), 32'(q.size() == 4));
      chk("afull", 32'(afull), 32'(q.size() >= 3));
      chk("aempty", 32'(aempty), 32'(q.size() <= 1));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
      if (q.size() != 0) chk("head", 32'(rddata), 32'(q[0]));
   endtask

   task automatic step(input logic p, input logic [7:0] d, input logic r);
      logic rok, wok;
      @(negedge clk);
      wrpush = p; wrdata = d; rdpop = r;
      rok = r && q.size() != 0;
      wok = p && (q.size() < 4 || rok);
      if (r && q.size() == 0) m_unf = 1'b1;
      if (p && !wok) m_ovf = 1'b1;
      #1;
      if (rok) chk("rddata", 32'(rddata), 32'(q[0]));
      @(posedge clk);
      if (rok) void'(q.pop_front());
      if (wok) q.push_back(d);
      #1;
      wrpush = 1'b0; rdpop = 1'b0;
      check_state();
   endtask

   task automatic do_reset(input logic p, input logic [7:0] d);
      @(negedge clk);
      reset_n = 1'b0; wrpush = p; wrdata = d; rdpop = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1; wrpush = 1'b0;
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      check_state();
   endtask

   task automatic fill();
      for (int i = 1; i <= 4; i++) step(1'b1, 8'(i * 8'h11), 1'b0);
   endtask

   task automatic drain();
      while (q.size() != 0) step(1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      // reset then idle
      do_reset(1'b0, 8'h00);
      step(1'b0, 8'h00, 1'b0);
      // fill and drain in order
      fill();
      drain();
      // full with simultaneous push and pop
      fill();
      step(1'b1, 8'h55, 1'b1);
      drain();
      // overflow when full, stays sticky
      fill();
      step(1'b1, 8'h66, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      drain();
      // underflow on empty pop
      step(1'b0, 8'h00, 1'b1);
      do_reset(1'b0, 8'h00);
      // empty with push and pop: push taken, pop ignored, underflow set
      step(1'b1, 8'h77, 1'b1);
      drain();
      do_reset(1'b0, 8'h00);
      // wrap-around with occupancy held at 2
      step(1'b1, 8'hA0, 1'b0);
      step(1'b1, 8'hA1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hB0 + i), 1'b1);
      drain();
      // reset mid-operation with a push pending
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
      do_reset(1'b1, 8'hEE);
      step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h5A, 1'b0);
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/scfifo.md
# scfifo

Parametrised single-clock first-word-fall-through FIFO, the same-clock successor to the dual-clock FIFO wrapper. It buffers words between pipeline stages of the modular squaring datapath that share one clock. It adds a programmable almost-full/almost-empty threshold, an occupancy count, sticky overflow/underflow error flags and simultaneous push/pop when full. It is written in plain RTL with a register-array memory, with no vendor macro.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- LOGDEPTH, 5, log2 of depth; DEPTH = 1<<LOGDEPTH (≥1)
- AFULL_THRESH, 8, afull asserts when count ≥ this value (1..DEPTH)
- AEMPTY_THRESH, 2, aempty asserts when count ≤ this value (0..DEPTH-1)

Ports:
- clk  in  1  sole clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- wrpush  in  1  write request
- wrdata  in  WIDTH  write data
- full  out  1  count == DEPTH
- afull  out  1  count ≥ AFULL_THRESH
- rdpop  in  1  consume head word
- rddata  out  WIDTH  head word (valid when rdvalid)
- rdvalid  out  1  FIFO not empty
- aempty  out  1  count ≤ AEMPTY_THRESH
- count  out  LOGDEPTH+1  occupancy, 0..DEPTH
- overflow  out  1  sticky: push dropped while full
- underflow  out  1  sticky: pop while empty

## Operation
- Storage: DEPTH×WIDTH register array; wrptr and rdptr are LOGDEPTH bits wide and wrap modulo DEPTH without special-casing.
- Write accepted (wr_ok) = wrpush & (~full | rd_ok). Read accepted (rd_ok) = rdpop & rdvalid.
- wr_ok: mem[wrptr] ← wrdata, wrptr++. rd_ok: rdptr++.
- count_next = count + wr_ok − rd_ok. Both accepted → count unchanged, both pointers advance.
- Full with push and pop in the same cycle: both are accepted and no overflow is flagged.
- Empty with push and pop in the same cycle: the push is accepted, the pop is ignored, and underflow is set. The pushed word is not bypassed to the output.
- wrpush & full & ~rdpop: the word is dropped and overflow ← 1.
- rdpop & ~rdvalid: no state change and underflow ← 1.
- overflow and underflow stay set until reset_n is low.
- full, afull, aempty and rdvalid are registered from count_next, so they are always consistent with count in the same cycle.
- rddata = mem[rdptr], an asynchronous read of the registered pointer (FWFT). rddata is X/don't-care when rdvalid is 0.

## Timing
- Reset on a clk edge with reset_n = 0:
  - count, rdvalid, full, afull, overflow and underflow go to 0.
  - aempty goes to 1.
  - Pointers go to 0.
  - Memory contents are not reset.
- Reset overrides any push or pop in the same cycle. A reset mid-operation discards all stored words.
- Write-to-read latency is 1 cycle: a push accepted at edge N gives rdvalid = 1 and rddata = the pushed word after edge N.
- Pop-to-next-word is 0 extra cycles: after the edge where a pop is accepted, rddata shows the next entry.
- Sustained throughput is one push plus one pop per cycle at any occupancy, including full.
- Flag update: every flag and count reflects all accepted operations up to and including the last edge. There is no pessimistic lag.
- Producer handshake: the producer should stop pushing when afull is sampled high. The headroom is DEPTH − AFULL_THRESH words to absorb pipeline slack.

## Test plan
Common parameters: WIDTH=8, LOGDEPTH=2, AFULL_THRESH=3, AEMPTY_THRESH=1.

1. Reset then idle: count=0, rdvalid=0, aempty=1, full=0, overflow=0, underflow=0.
2. Fill and drain:
   - Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
   - afull rises with count=3; full=1 with count=4.
   - Pop 4 times: rddata reads 0x11, 0x22, 0x33, 0x44 in that order, then rdvalid=0.
3. Full with simultaneous push and pop:
   - Start full with 0x11..0x44. Push 0x55 and pop in the same cycle.
   - Result: count stays 4, rddata=0x22, overflow=0. Draining returns 0x22, 0x33, 0x44, 0x55.
4. Overflow and underflow:
   - Full, push 0x66 with no pop: count stays 4 and overflow=1, staying 1 afterwards.
   - Empty, pop: underflow=1 and count stays 0.
   - reset_n low for one cycle clears both flags.
5. Wrap-around:
   - Run 10 cycles of push i / pop with occupancy held at 2.
   - Output sequence equals input sequence, and the pointers wrap past 3→0 with no loss.
6. Reset mid-operation: with count=3, pulse reset_n low while wrpush=1. Required result: count=0, rdvalid=0, and the push is not stored.
